mem_store_port: RTL and testbench
=================================

MEM_STORE_PORT -- requirements
Module: mem_store_port

Interface
REQ-001 Reset rst, synchronous, active-high; clock clk.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall_i  input  1  bus-lost indication from ctrl; 1 = byte on bus this cycle not accepted.
REQ-005 req_i  input  1  store request from MEM stage; sampled only in IDLE.
REQ-006 addr_i  input  32  byte address of first byte to store.
REQ-007 data_i  input  32  store data; byte k = data_i[8k+7:8k].
REQ-008 size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 mem_a_o  output  32  byte address driven to byte-wide memory.
REQ-010 mem_dout_o  output  8  write data byte.
REQ-011 mem_wr_o  output  1  1 = write strobe for current byte.
REQ-012 mem_ctrl_req_o  output  1  1 = stall request to ctrl while store in progress (Stop).
REQ-013 done_o  output  1  one-cycle pulse: store complete.
REQ-014 inv_o  output  1  one-cycle pulse per committed byte, to fetch-stage icache.
REQ-015 inv_addr_o  output  32  byte address of committed byte (valid when inv_o=1).

Function
REQ-016 States IDLE, WRITE, PAUSE, DONE; all outputs registered.
REQ-017 IDLE: if req_i=1 and stall_i=0, latch addr/data/size, n = 1/2/4, k=0; next cycle WRITE with mem_a_o=addr, mem_dout_o=data[7:0], mem_wr_o=1, mem_ctrl_req_o=1.
REQ-018 IDLE with stall_i=1: req_i ignored; upstream holds req_i until accepted.
REQ-019 WRITE, edge with stall_i=0: byte k committed; inv_o=1, inv_addr_o=addr+k next cycle; if k<n-1 then k+1 driven (mem_a_o=addr+k+1, mem_dout_o=byte k+1), else DONE.
REQ-020 WRITE, edge with stall_i=1: byte k not committed; next cycle PAUSE, mem_wr_o=0, k held, mem_ctrl_req_o stays 1.
REQ-021 PAUSE: while stall_i=1 hold; on stall_i=0 re-drive byte k (mem_wr_o=1), return WRITE.
REQ-022 DONE: one cycle, done_o=1, mem_wr_o=0, mem_ctrl_req_o=0; then IDLE; req_i in DONE ignored.
REQ-023 Address arithmetic 32-bit modulo: 0xFFFFFFFF+1 = 0x00000000; unaligned stores permitted, no alignment fault.
REQ-024 Latency with no stall: byte store done_o 2 cycles after acceptance edge, half 3, word 5.
REQ-025 Each byte written exactly once: no duplicate commit across PAUSE.
REQ-026 Outside WRITE, mem_wr_o=0, mem_dout_o=0; inv_o=0 except the cycle after a commit.

Reset
REQ-027 rst=1 at any edge, including mid-store: state IDLE, k=0, all outputs 0, latched addr/data 0; uncommitted bytes are abandoned, no further write.
REQ-028 rst has priority over stall_i and req_i.

Structure
REQ-029 defines.v holds size codes (StoreByte/Half/Word), state encodings, Stop/NoStop, ZeroWord.
REQ-030 Single module, no sub-module; byte select is an inline mux on k.

Verification
REQ-031 SW addr 0x00001000, data 0xDEADBEEF, no stall -> writes EF,BE,AD,DE to 0x1000..0x1003 on 4 consecutive cycles, done_o 5 cycles after accept, 4 inv_o pulses.
REQ-032 SH addr 0x00000FFF, data 0x00001234 -> 34 at 0xFFF, 12 at 0x1000 (word-crossing), done_o once.
REQ-033 SW with stall_i=1 for 3 cycles while byte 2 driven -> byte 2 written exactly once after stall drops, memory image identical to REQ-031, done_o delayed by 4 cycles.
REQ-034 SB addr 0xFFFFFFFF then SH addr 0xFFFFFFFF -> second byte wraps to 0x00000000.
REQ-035 rst asserted after byte 1 of SW -> only bytes 0,1 in memory, all outputs 0 next cycle, no done_o.
REQ-036 req_i held high through DONE -> exactly one store per acceptance; second store accepted only in IDLE.

Source files
------------

// File: rtl/mem_store_port_pkg.sv
// Shared constants and types for the byte-serial store port.
// Size codes, FSM states and the last-byte index helper.
package mem_store_port_pkg;

    localparam logic [1:0]  StoreByte = 2'b00;
    localparam logic [1:0]  StoreHalf = 2'b01;
    localparam logic [1:0]  StoreWord = 2'b10;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } store_state_t;

    // Index of the final byte for a size code; 11 behaves like a word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            StoreByte: return 2'd0;
            StoreHalf: return 2'd1;
            StoreWord: return 2'd3;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_port.sv
// Byte-serial store port: splits a MEM-stage store into byte writes,
// survives bus loss by pausing, and reports each committed byte.
module mem_store_port
    import mem_store_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    output logic        mem_wr_o,
    output logic        mem_ctrl_req_o,
    output logic        done_o,
    output logic        inv_o,
    output logic [31:0] inv_addr_o
);

    store_state_t state_q, state_d;

    logic [1:0]  k_q, k_d, k_next;
    logic [1:0]  last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_a_d, inv_addr_d;
    logic [7:0]  dout_d, byte_cur, byte_next;
    logic        wr_d, ctrl_d, done_d, inv_d;

    assign k_next    = k_q + 2'd1;
    assign byte_cur  = data_q[{k_q, 3'b000} +: 8];
    assign byte_next = data_q[{k_next, 3'b000} +: 8];

    // State, latched store and registered outputs; reset abandons any store.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            k_q            <= 2'd0;
            last_q         <= 2'd0;
            addr_q         <= ZeroWord;
            data_q         <= ZeroWord;
            mem_a_o        <= ZeroWord;
            mem_dout_o     <= 8'h00;
            mem_wr_o       <= 1'b0;
            mem_ctrl_req_o <= NoStop;
            done_o         <= 1'b0;
            inv_o          <= 1'b0;
            inv_addr_o     <= ZeroWord;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            last_q         <= last_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            mem_a_o        <= mem_a_d;
            mem_dout_o     <= dout_d;
            mem_wr_o       <= wr_d;
            mem_ctrl_req_o <= ctrl_d;
            done_o         <= done_d;
            inv_o          <= inv_d;
            inv_addr_o     <= inv_addr_d;
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        last_d     = last_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mem_a_d    = mem_a_o;
        dout_d     = 8'h00;
        wr_d       = 1'b0;
        ctrl_d     = NoStop;
        done_d     = 1'b0;
        inv_d      = 1'b0;
        inv_addr_d = inv_addr_o;

        unique case (state_q)
            ST_IDLE: begin
                mem_a_d = ZeroWord;
                if (req_i && !stall_i) begin
                    addr_d  = addr_i;
                    data_d  = data_i;
                    last_d  = last_index(size_i);
                    k_d     = 2'd0;
                    mem_a_d = addr_i;
                    dout_d  = data_i[7:0];
                    wr_d    = 1'b1;
                    ctrl_d  = Stop;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!stall_i) begin
                    inv_d      = 1'b1;
                    inv_addr_d = addr_q + {30'd0, k_q};
                    if (k_q != last_q) begin
                        k_d     = k_next;
                        mem_a_d = addr_q + {30'd0, k_next};
                        dout_d  = byte_next;
                        wr_d    = 1'b1;
                        ctrl_d  = Stop;
                    end else begin
                        k_d     = 2'd0;
                        mem_a_d = ZeroWord;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    ctrl_d  = Stop;
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                ctrl_d = Stop;
                if (!stall_i) begin
                    dout_d  = byte_cur;
                    wr_d    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                mem_a_d = ZeroWord;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_store_port.sv
// Self-checking bench for mem_store_port: directed store scenarios
// plus randomized stores with random bus loss against a byte-level model.
module tb_mem_store_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  size_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic        mem_ctrl_req_o;
    logic        done_o;
    logic        inv_o;
    logic [31:0] inv_addr_o;

    mem_store_port dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .req_i          (req_i),
        .addr_i         (addr_i),
        .data_i         (data_i),
        .size_i         (size_i),
        .mem_a_o        (mem_a_o),
        .mem_dout_o     (mem_dout_o),
        .mem_wr_o       (mem_wr_o),
        .mem_ctrl_req_o (mem_ctrl_req_o),
        .done_o         (done_o),
        .inv_o          (inv_o),
        .inv_addr_o     (inv_addr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Observations of the most recent store, cycle 0 = acceptance cycle.
    logic [31:0] c_addr[$];
    logic [7:0]  c_byte[$];
    int          c_cyc[$];
    logic [31:0] i_addr[$];
    int          i_cyc[$];
    int          done_cnt;
    int          done_cyc;
    int          out_err;
    int          ctrl_err;
    bit          idle_clean;
    bit          timed_out;

    function automatic int n_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Issues one store from IDLE and records bus activity until the
    // port is observed back in IDLE. Entry/exit: #1 after a posedge.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s, input logic [31:0] mask,
                             input bit rand_stall);
        int  c;
        bit  stl;
        bit  fin;
        c_addr.delete(); c_byte.delete(); c_cyc.delete();
        i_addr.delete(); i_cyc.delete();
        done_cnt = 0; done_cyc = -1; out_err = 0; ctrl_err = 0;
        idle_clean = 1'b0; timed_out = 1'b0;
        req_i = 1'b1; addr_i = a; data_i = d; size_i = s; stall_i = 1'b0;
        c = 0;
        fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            c++;
            req_i  = 1'b0;
            addr_i = $urandom;
            data_i = $urandom;
            size_i = 2'($urandom_range(0, 3));
            if (rand_stall) stl = ($urandom_range(0, 2) == 0);
            else            stl = (c < 32) ? mask[c] : 1'b0;
            stall_i = stl;
            if (done_cnt > 0 && c == done_cyc + 1) begin
                idle_clean = (mem_wr_o === 1'b0) && (mem_ctrl_req_o === 1'b0) &&
                             (done_o === 1'b0) && (inv_o === 1'b0) &&
                             (mem_dout_o === 8'h00);
                fin = 1'b1;
            end else begin
                if (mem_wr_o && !stl) begin
                    c_addr.push_back(mem_a_o);
                    c_byte.push_back(mem_dout_o);
                    c_cyc.push_back(c);
                end
                if (!mem_wr_o && mem_dout_o !== 8'h00) out_err++;
                if (inv_o) begin
                    i_addr.push_back(inv_addr_o);
                    i_cyc.push_back(c);
                end
                if (done_o) begin
                    done_cnt++;
                    done_cyc = c;
                    if (mem_ctrl_req_o !== 1'b0) ctrl_err++;
                end else if (mem_ctrl_req_o !== 1'b1) begin
                    ctrl_err++;
                end
            end
            if (c >= 300) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b0; req_i = 1'b1;
        addr_i = 32'h1234_5678; data_i = 32'hFFFF_FFFF; size_i = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_a_o, mem_dout_o, mem_wr_o, mem_ctrl_req_o, done_o, inv_o, inv_addr_o} !== '0)
            $display("FAIL reset_outputs: got a=%h d=%h wr=%b ctrl=%b done=%b inv=%b ia=%h want all 0",
                     mem_a_o, mem_dout_o, mem_wr_o, mem_ctrl_req_o, done_o, inv_o, inv_addr_o);
        else passed++;
        rst = 1'b0; req_i = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] d;
        d = 32'hDEAD_BEEF;
        run_store(32'h0000_1000, d, 2'b10, 32'h0, 1'b0);
        checks++;
        if (c_addr.size() != 4 || timed_out)
            $display("FAIL sw_count: got %0d writes want 4", c_addr.size());
        else passed++;
        for (int i = 0; i < 4 && i < c_addr.size(); i++) begin
            checks++;
            if (c_addr[i] !== 32'h1000 + i || c_byte[i] !== d[8*i +: 8] || c_cyc[i] != i + 1)
                $display("FAIL sw_byte%0d: got %h@%h cyc %0d want %h@%h cyc %0d",
                         i, c_byte[i], c_addr[i], c_cyc[i], d[8*i +: 8], 32'h1000 + i, i + 1);
            else passed++;
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 5)
            $display("FAIL sw_done: got cnt %0d cyc %0d want 1 / 5", done_cnt, done_cyc);
        else passed++;
        checks++;
        if (i_addr.size() != 4 || ctrl_err != 0 || out_err != 0 || !idle_clean)
            $display("FAIL sw_side: got inv %0d ctrl_err %0d out_err %0d idle %0b want 4 0 0 1",
                     i_addr.size(), ctrl_err, out_err, idle_clean);
        else passed++;
    endtask

    task automatic test_half_cross();
        run_store(32'h0000_0FFF, 32'h0000_1234, 2'b01, 32'h0, 1'b0);
        checks++;
        if (c_addr.size() != 2 || c_addr[0] !== 32'h0FFF || c_byte[0] !== 8'h34 ||
            c_addr[1] !== 32'h1000 || c_byte[1] !== 8'h12)
            $display("FAIL sh_cross: got %0d writes first %h@%h want 34@00000fff 12@00001000",
                     c_addr.size(), (c_byte.size() > 0) ? c_byte[0] : 8'hxx,
                     (c_addr.size() > 0) ? c_addr[0] : 32'hx);
        else passed++;
        checks++;
        if (done_cnt != 1 || done_cyc != 3)
            $display("FAIL sh_done: got cnt %0d cyc %0d want 1 / 3", done_cnt, done_cyc);
        else passed++;
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = 32'hDEAD_BEEF;
        run_store(32'h0000_1000, d, 2'b10, 32'h0000_0038, 1'b0);
        checks++;
        if (c_addr.size() != 4)
            $display("FAIL stall_count: got %0d writes want 4", c_addr.size());
        else passed++;
        for (int i = 0; i < 4 && i < c_addr.size(); i++) begin
            checks++;
            if (c_addr[i] !== 32'h1000 + i || c_byte[i] !== d[8*i +: 8])
                $display("FAIL stall_byte%0d: got %h@%h want %h@%h",
                         i, c_byte[i], c_addr[i], d[8*i +: 8], 32'h1000 + i);
            else passed++;
        end
        checks++;
        if (c_cyc.size() == 4 && c_cyc[2] != 7)
            $display("FAIL stall_redrive: got byte2 commit cyc %0d want 7", c_cyc[2]);
        else if (c_cyc.size() == 4) passed++;
        else $display("FAIL stall_redrive: got %0d commits want 4", c_cyc.size());
        checks++;
        if (done_cnt != 1 || done_cyc != 9 || out_err != 0 || ctrl_err != 0)
            $display("FAIL stall_done: got cnt %0d cyc %0d out_err %0d ctrl_err %0d want 1 9 0 0",
                     done_cnt, done_cyc, out_err, ctrl_err);
        else passed++;
    endtask

    task automatic test_wrap();
        run_store(32'hFFFF_FFFF, 32'h0000_00C3, 2'b00, 32'h0, 1'b0);
        checks++;
        if (c_addr.size() != 1 || c_addr[0] !== 32'hFFFF_FFFF || c_byte[0] !== 8'hC3 ||
            done_cyc != 2)
            $display("FAIL sb_top: got %0d writes done cyc %0d want 1 write c3@ffffffff done 2",
                     c_addr.size(), done_cyc);
        else passed++;
        run_store(32'hFFFF_FFFF, 32'h0000_A55A, 2'b01, 32'h0, 1'b0);
        checks++;
        if (c_addr.size() != 2 || c_addr[1] !== 32'h0 || c_byte[1] !== 8'hA5 ||
            i_addr.size() != 2 || i_addr[1] !== 32'h0)
            $display("FAIL sh_wrap: got %0d writes %0d invs want a5@00000000 and inv 00000000",
                     c_addr.size(), i_addr.size());
        else passed++;
    endtask

    task automatic test_size3();
        run_store(32'h0000_0202, 32'h0102_0304, 2'b11, 32'h0, 1'b0);
        checks++;
        if (c_addr.size() != 4 || done_cyc != 5 || c_byte[3] !== 8'h01 ||
            c_addr[3] !== 32'h0205)
            $display("FAIL size11_word: got %0d writes done cyc %0d want 4 / 5",
                     c_addr.size(), done_cyc);
        else passed++;
    endtask

    task automatic test_idle_stall();
        req_i = 1'b1; stall_i = 1'b1;
        addr_i = 32'h0000_4000; data_i = 32'h0000_0077; size_i = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (mem_wr_o !== 1'b0 || mem_ctrl_req_o !== 1'b0)
            $display("FAIL idle_stall_ignored: got wr=%b ctrl=%b want 0 0",
                     mem_wr_o, mem_ctrl_req_o);
        else passed++;
        run_store(32'h0000_4000, 32'h0000_0077, 2'b00, 32'h0, 1'b0);
        checks++;
        if (c_addr.size() != 1 || c_byte[0] !== 8'h77 || done_cyc != 2)
            $display("FAIL idle_stall_then_accept: got %0d writes done %0d want 1 / 2",
                     c_addr.size(), done_cyc);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int  wr_cnt;
        int  dn;
        bit  zero_ok;
        bit  order_ok;
        wr_cnt = 0; dn = 0; zero_ok = 1'b0; order_ok = 1'b1;
        req_i = 1'b1; stall_i = 1'b0;
        addr_i = 32'h0000_2000; data_i = 32'h1122_3344; size_i = 2'b10;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            req_i = 1'b0;
            rst = (c == 3);
            if (c == 4)
                zero_ok = ({mem_a_o, mem_dout_o, mem_wr_o, mem_ctrl_req_o,
                            done_o, inv_o, inv_addr_o} === '0);
            if (mem_wr_o && !rst) begin
                if (wr_cnt == 0 && (mem_a_o !== 32'h2000 || mem_dout_o !== 8'h44)) order_ok = 1'b0;
                if (wr_cnt == 1 && (mem_a_o !== 32'h2001 || mem_dout_o !== 8'h33)) order_ok = 1'b0;
                wr_cnt++;
            end
            if (done_o) dn++;
        end
        rst = 1'b0;
        checks++;
        if (wr_cnt != 2 || !order_ok)
            $display("FAIL rst_mid_writes: got %0d writes order_ok %0b want 2 writes 44,33", wr_cnt, order_ok);
        else passed++;
        checks++;
        if (!zero_ok || dn != 0)
            $display("FAIL rst_mid_outputs: got zero %0b done %0d want 1 / 0", zero_ok, dn);
        else passed++;
    endtask

    task automatic test_hold_req();
        int wr_cnt;
        int dn;
        int exp_st;
        wr_cnt = 0; dn = 0;
        req_i = 1'b1; stall_i = 1'b0;
        addr_i = 32'h0000_3000; data_i = 32'h0000_005A; size_i = 2'b00;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            req_i = (c < 12);
            if (mem_wr_o) wr_cnt++;
            if (done_o) dn++;
        end
        req_i = 1'b0;
        // A byte store occupies WRITE then DONE, so acceptances fall
        // every third cycle from cycle 0 while req_i stays high.
        exp_st = 0;
        for (int a = 0; a < 12; a += n_bytes(2'b00) + 2)
            if (a + n_bytes(2'b00) + 1 <= 12) exp_st++;
        checks++;
        if (wr_cnt != exp_st || dn != exp_st)
            $display("FAIL hold_req: got %0d writes %0d dones want %0d each", wr_cnt, dn, exp_st);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        int          n;
        bit          ok;
        for (int t = 0; t < 24; t++) begin
            a = (t % 4 == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            d = $urandom;
            s = 2'($urandom_range(0, 3));
            n = n_bytes(s);
            run_store(a, d, s, 32'h0, 1'b1);
            checks++;
            if (timed_out || c_addr.size() != n || done_cnt != 1)
                $display("FAIL rnd%0d_count: got %0d writes %0d dones want %0d / 1",
                         t, c_addr.size(), done_cnt, n);
            else passed++;
            ok = (c_addr.size() == n) && (i_addr.size() == n);
            for (int i = 0; i < n && ok; i++) begin
                if (c_addr[i] !== a + 32'(i) || c_byte[i] !== d[8*i +: 8]) ok = 1'b0;
                if (i_addr[i] !== c_addr[i] || i_cyc[i] != c_cyc[i] + 1) ok = 1'b0;
            end
            checks++;
            if (!ok)
                $display("FAIL rnd%0d_image: addr %h data %h size %0d got %0d writes %0d invs want exact bytes",
                         t, a, d, s, c_addr.size(), i_addr.size());
            else passed++;
            checks++;
            if (c_cyc.size() == 0 || done_cyc != c_cyc[c_cyc.size() - 1] + 1 ||
                out_err != 0 || ctrl_err != 0 || !idle_clean)
                $display("FAIL rnd%0d_timing: got done cyc %0d out_err %0d ctrl_err %0d idle %0b want done after last commit, 0 0 1",
                         t, done_cyc, out_err, ctrl_err, idle_clean);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_half_cross();
        test_stall();
        test_wrap();
        test_size3();
        test_idle_stall();
        test_reset_mid();
        test_hold_req();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
